// File: rtl/adc_spi_multilane_master.sv
// Multi-lane SPI master for simultaneous-sampling ADCs: one SCLK/SS pair, N_CHANNELS MISO lanes,
// captured words drained as an AXI-stream burst with tdest = channel index.
module adc_spi_multilane_master #(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIV_WIDTH  = 8,
  localparam int unsigned LEN_WIDTH = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cfg_enable,
  input  logic [DIV_WIDTH-1:0]  cfg_divider,
  input  logic [LEN_WIDTH-1:0]  cfg_length,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic [N_CHANNELS-1:0] MISO,
  output logic                  SCLK,
  output logic                  SS,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [7:0]            m_dest,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  overrun
);

  localparam int unsigned IDX_WIDTH  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int unsigned EDGE_WIDTH = LEN_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q, cnt_q;
  logic [LEN_WIDTH-1:0]  len_q, len_eff;
  logic                  cpol_q, cpha_q;
  logic [EDGE_WIDTH-1:0] edge_q;
  logic                  sclk_q, ss_q, busy_q, overrun_q;
  logic [DATA_WIDTH-1:0] shreg_q [N_CHANNELS];
  logic [DATA_WIDTH-1:0] buf_q   [N_CHANNELS];
  logic                  buf_full_q;
  logic [IDX_WIDTH-1:0]  rd_idx_q;

  logic accept, tick, edge_last, beat, drain_done, can_load;

  always_comb begin
    accept     = (state_q == StIdle) && start && cfg_enable;
    tick       = (cnt_q == div_q);
    edge_last  = (edge_q == ({len_q, 1'b0} - EDGE_WIDTH'(1)));
    beat       = buf_full_q && m_ready;
    drain_done = beat && (rd_idx_q == IDX_WIDTH'(N_CHANNELS - 1));
    // The buffer may be refilled on the very cycle its last beat leaves.
    can_load   = !buf_full_q || drain_done;
    len_eff    = cfg_length;
    if ((cfg_length == '0) || (cfg_length > LEN_WIDTH'(DATA_WIDTH))) begin
      len_eff = LEN_WIDTH'(DATA_WIDTH);
    end

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StSetup;
      StSetup: if (tick) state_d = StShift;
      StShift: if (tick && edge_last) state_d = StHold;
      StHold:  if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      div_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      edge_q     <= '0;
      sclk_q     <= 1'b0;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      buf_full_q <= 1'b0;
      rd_idx_q   <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        shreg_q[i] <= '0;
        buf_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      overrun_q <= 1'b0;

      if (beat) begin
        if (drain_done) begin
          buf_full_q <= 1'b0;
          rd_idx_q   <= '0;
        end else begin
          rd_idx_q <= rd_idx_q + IDX_WIDTH'(1);
        end
      end

      if (state_q != StIdle) begin
        cnt_q <= tick ? '0 : cnt_q + DIV_WIDTH'(1);
      end

      unique case (state_q)
        StIdle: begin
          sclk_q <= cfg_cpol;
          if (accept) begin
            ss_q   <= 1'b0;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            edge_q <= '0;
            div_q  <= cfg_divider;
            len_q  <= len_eff;
            cpol_q <= cfg_cpol;
            cpha_q <= cfg_cpha;
            for (int i = 0; i < N_CHANNELS; i++) shreg_q[i] <= '0;
          end
        end
        StSetup: ;
        StShift: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + EDGE_WIDTH'(1);
            // Even edge count means a leading edge is next; cpha picks which edge samples.
            if (edge_q[0] == cpha_q) begin
              for (int i = 0; i < N_CHANNELS; i++) begin
                shreg_q[i] <= {shreg_q[i][DATA_WIDTH-2:0], MISO[i]};
              end
            end
          end
        end
        StHold: begin
          sclk_q <= cpol_q;
          if (tick) begin
            ss_q   <= 1'b1;
            busy_q <= 1'b0;
            if (can_load) begin
              for (int i = 0; i < N_CHANNELS; i++) buf_q[i] <= shreg_q[i];
              buf_full_q <= 1'b1;
              rd_idx_q   <= '0;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign SCLK    = sclk_q;
  assign SS      = ss_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;
  assign m_valid = buf_full_q;
  assign m_last  = buf_full_q && (rd_idx_q == IDX_WIDTH'(N_CHANNELS - 1));
  assign m_data  = buf_q[rd_idx_q];
  assign m_dest  = 8'(rd_idx_q);

endmodule
